mem_state: RTL and testbench

Memory-access stage of the five-stage RV32 pipeline, sitting between the execute stage and the write-back stage. Holds one instruction from execute, issues its data-memory read or write through a valid/ready handshake, aligns and sign-/zero-extends load data, and presents a 70-bit result bus to write-back. Also exports a forwarding/hazard bus to decode.

---
 rtl/mem_state.sv | 130 +++++++++++++
 tb/tb_mem_state.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_state.sv
// Memory-access stage of the RV32 pipeline: holds one instruction from execute,
// performs its data-memory handshake, aligns load data and hands the result to write-back.
module mem_state (
   input  logic         clk,
   input  logic         rst,
   output logic         MEM_Allow_in,
   input  logic         EX_to_MEM_Valid,
   input  logic [106:0] EX_to_MEM_Bus,
   output logic [31:0]  Address,
   output logic         MemRead,
   output logic         MemWrite,
   output logic [31:0]  Write_data,
   output logic [3:0]   Write_strb,
   input  logic         Mem_Req_Ready,
   input  logic [31:0]  Read_data,
   input  logic         Read_data_Valid,
   output logic         Read_data_Ready,
   input  logic         WB_Allow_in,
   output logic         MEM_to_WB_Valid,
   output logic [69:0]  MEM_to_WB_Bus,
   output logic [38:0]  rdw_MEM_Bus,
   output logic         MEM_load_busy
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t        state, state_nxt;
   logic [106:0]  bus_r;
   logic [31:0]   rdata_r;

   logic          is_load, is_store, wen, wen_out, capture, mem_valid;
   logic          in_is_mem;
   logic [2:0]    funct3;
   logic [31:0]   store_data, alu_result, pc, load_val, final_result;
   logic [4:0]    waddr;
   logic [1:0]    off;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [3:0]    strb;

   assign is_load    = bus_r[106];
   assign is_store   = bus_r[105];
   assign funct3     = bus_r[104:102];
   assign store_data = bus_r[101:70];
   assign wen        = bus_r[69];
   assign waddr      = bus_r[68:64];
   assign alu_result = bus_r[63:32];
   assign pc         = bus_r[31:0];
   assign off        = alu_result[1:0];
   assign in_is_mem  = EX_to_MEM_Bus[106] | EX_to_MEM_Bus[105];

   assign mem_valid    = (state != IDLE);
   assign MEM_Allow_in = (state == IDLE) | ((state == DONE) & WB_Allow_in);
   assign capture      = EX_to_MEM_Valid & MEM_Allow_in;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Data registers carry no reset: they are only observed once the state says they are valid.
   always_ff @(posedge clk) begin
      if (rst && capture) bus_r <= EX_to_MEM_Bus;
      if (rst && state == WAIT && Read_data_Valid) rdata_r <= Read_data;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (capture) state_nxt = in_is_mem ? REQ : DONE;
         REQ:  if (Mem_Req_Ready) state_nxt = is_load ? WAIT : DONE;
         WAIT: if (Read_data_Valid) state_nxt = DONE;
         DONE: begin
            if (WB_Allow_in) begin
               if (capture) state_nxt = in_is_mem ? REQ : DONE;
               else         state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      strb       = 4'b1111;
      Write_data = store_data;
      case (funct3[1:0])
         2'b00: begin
            strb       = 4'b0001 << off;
            Write_data = {4{store_data[7:0]}};
         end
         2'b01: begin
            strb       = off[1] ? 4'b1100 : 4'b0011;
            Write_data = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = rdata_r[7:0];
      case (off)
         2'd1:    ld_byte = rdata_r[15:8];
         2'd2:    ld_byte = rdata_r[23:16];
         2'd3:    ld_byte = rdata_r[31:24];
         default: ;
      endcase
      ld_half  = off[1] ? rdata_r[31:16] : rdata_r[15:0];
      load_val = rdata_r;
      // funct3[2] distinguishes the unsigned variants (LBU/LHU).
      case (funct3[1:0])
         2'b00:   load_val = {{24{~funct3[2] & ld_byte[7]}}, ld_byte};
         2'b01:   load_val = {{16{~funct3[2] & ld_half[15]}}, ld_half};
         default: ;
      endcase
   end

   assign final_result = is_load ? load_val : alu_result;
   assign wen_out      = wen & ~is_store;

   assign Address         = {alu_result[31:2], 2'b00};
   assign MemRead         = (state == REQ) & is_load;
   assign MemWrite        = (state == REQ) & is_store;
   assign Write_strb      = ((state == REQ) & is_store) ? strb : 4'b0000;
   assign Read_data_Ready = (state == WAIT);
   assign MEM_to_WB_Valid = (state == DONE);
   assign MEM_to_WB_Bus   = {wen_out, waddr, final_result, pc};
   assign rdw_MEM_Bus     = {mem_valid, mem_valid & wen_out, waddr, final_result};
   assign MEM_load_busy   = is_load & ((state == REQ) | (state == WAIT));

endmodule

// File: tb/tb_mem_state.sv
// Self-checking bench for mem_state: directed scenarios plus a randomized run
// checked against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_mem_state;

   logic         clk, rst;
   logic         MEM_Allow_in, EX_to_MEM_Valid;
   logic [106:0] EX_to_MEM_Bus;
   logic [31:0]  Address, Write_data, Read_data;
   logic         MemRead, MemWrite, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
   logic [3:0]   Write_strb;
   logic         WB_Allow_in, MEM_to_WB_Valid, MEM_load_busy;
   logic [69:0]  MEM_to_WB_Bus;
   logic [38:0]  rdw_MEM_Bus;

   int errors = 0;
   int checks = 0;

   mem_state dut (
      .clk(clk), .rst(rst), .MEM_Allow_in(MEM_Allow_in),
      .EX_to_MEM_Valid(EX_to_MEM_Valid), .EX_to_MEM_Bus(EX_to_MEM_Bus),
      .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
      .Write_data(Write_data), .Write_strb(Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
      .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
      .WB_Allow_in(WB_Allow_in), .MEM_to_WB_Valid(MEM_to_WB_Valid), .MEM_to_WB_Bus(MEM_to_WB_Bus),
      .rdw_MEM_Bus(rdw_MEM_Bus), .MEM_load_busy(MEM_load_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [106:0] mk_bus(input logic ld, input logic st, input logic [2:0] f3,
                                           input logic [31:0] sd, input logic wen, input logic [4:0] wa,
                                           input logic [31:0] alu, input logic [31:0] pc);
      return {ld, st, f3, sd, wen, wa, alu, pc};
   endfunction

   // Reference rules, written as arithmetic on the word.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
      longint unsigned w, v;
      int unsigned o;
      w = word;
      o = off;
      if (f3 == 3'd0 || f3 == 3'd4) begin
         v = (w >> (8 * o)) % 256;
         if (f3 == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
         v = (w >> (16 * (o / 2))) % 65536;
         if (f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
      end else begin
         v = w;
      end
      return v[31:0];
   endfunction

   function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] off);
      int unsigned o;
      o = off;
      if (f3 == 3'd0) return 4'(1 << o);
      if (f3 == 3'd1) return (o >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
      longint unsigned s, v;
      s = sd;
      if (f3 == 3'd0)      v = (s % 256) * 64'h0101_0101;
      else if (f3 == 3'd1) v = (s % 65536) * 64'h0001_0001;
      else                 v = s;
      return v[31:0];
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      EX_to_MEM_Valid = 1'b1;
      EX_to_MEM_Bus = mk_bus(1'b1, 1'b0, 3'd2, 32'h0, 1'b1, 5'd1, 32'h100, 32'h0);
      WB_Allow_in = 1'b1;
      Mem_Req_Ready = 1'b1;
      Read_data_Valid = 1'b1;
      Read_data = 32'h0;
      tick();
      tick();
      checks++;
      if ({MemRead, MemWrite, Read_data_Ready, MEM_to_WB_Valid, MEM_load_busy, rdw_MEM_Bus[38]} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {MemRead, MemWrite, Read_data_Ready, MEM_to_WB_Valid, MEM_load_busy, rdw_MEM_Bus[38]});
      end
      checks++;
      if (Write_strb !== 4'b0) begin
         errors++;
         $display("FAIL reset_strb: got %b expected 0000", Write_strb);
      end
      checks++;
      if (MEM_Allow_in !== 1'b1) begin
         errors++;
         $display("FAIL reset_allow_in: got %b expected 1", MEM_Allow_in);
      end
      rst = 1'b1;
      EX_to_MEM_Valid = 1'b0;
      Mem_Req_Ready = 1'b0;
      Read_data_Valid = 1'b0;
      tick();
   endtask

   task automatic test_alu_passthrough();
      logic [69:0] exp;
      WB_Allow_in = 1'b1;
      EX_to_MEM_Valid = 1'b1;
      EX_to_MEM_Bus = mk_bus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 5'd5, 32'h11, 32'h40);
      tick();
      EX_to_MEM_Bus = mk_bus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 5'd5, 32'h22, 32'h44);
      exp = {1'b1, 5'd5, 32'h11, 32'h40};
      checks++;
      if (MEM_to_WB_Valid !== 1'b1 || MEM_to_WB_Bus !== exp || {MemRead, MemWrite} !== 2'b00) begin
         errors++;
         $display("FAIL alu_first: got v=%b bus=%h req=%b expected v=1 bus=%h req=00",
                  MEM_to_WB_Valid, MEM_to_WB_Bus, {MemRead, MemWrite}, exp);
      end
      tick();
      EX_to_MEM_Valid = 1'b0;
      exp = {1'b1, 5'd5, 32'h22, 32'h44};
      checks++;
      if (MEM_to_WB_Valid !== 1'b1 || MEM_to_WB_Bus !== exp || {MemRead, MemWrite} !== 2'b00) begin
         errors++;
         $display("FAIL alu_second: got v=%b bus=%h req=%b expected v=1 bus=%h req=00",
                  MEM_to_WB_Valid, MEM_to_WB_Bus, {MemRead, MemWrite}, exp);
      end
      tick();
      checks++;
      if (MEM_to_WB_Valid !== 1'b0) begin
         errors++;
         $display("FAIL alu_drain: got valid=%b expected 0", MEM_to_WB_Valid);
      end
   endtask

   task automatic test_lb(input logic unsigned_ld, input logic [31:0] expected);
      WB_Allow_in = 1'b1;
      Mem_Req_Ready = 1'b0;
      Read_data_Valid = 1'b1;
      Read_data = 32'hDEAD_BEEF;
      EX_to_MEM_Valid = 1'b1;
      EX_to_MEM_Bus = mk_bus(1'b1, 1'b0, unsigned_ld ? 3'd4 : 3'd0, 32'h0, 1'b1, 5'd3, 32'h1003, 32'h200);
      tick();
      EX_to_MEM_Valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (Address !== 32'h1000 || MemRead !== 1'b1 || MEM_load_busy !== 1'b1) begin
            errors++;
            $display("FAIL lb_req_hold: got addr=%h rd=%b busy=%b expected addr=00001000 rd=1 busy=1",
                     Address, MemRead, MEM_load_busy);
         end
         tick();
      end
      Mem_Req_Ready = 1'b1;
      Read_data_Valid = 1'b0;
      tick();
      Mem_Req_Ready = 1'b0;
      checks++;
      if (Read_data_Ready !== 1'b1 || MemRead !== 1'b0 || Address !== 32'h1000) begin
         errors++;
         $display("FAIL lb_wait: got rdy=%b rd=%b addr=%h expected rdy=1 rd=0 addr=00001000",
                  Read_data_Ready, MemRead, Address);
      end
      Read_data = 32'h80FF_1234;
      Read_data_Valid = 1'b1;
      tick();
      Read_data_Valid = 1'b0;
      checks++;
      if (MEM_to_WB_Valid !== 1'b1 || MEM_to_WB_Bus[63:32] !== expected || rdw_MEM_Bus[31:0] !== expected) begin
         errors++;
         $display("FAIL lb_result: got v=%b res=%h fwd=%h expected v=1 res=%h",
                  MEM_to_WB_Valid, MEM_to_WB_Bus[63:32], rdw_MEM_Bus[31:0], expected);
      end
      tick();
   endtask

   task automatic test_sh_upper();
      WB_Allow_in = 1'b1;
      Mem_Req_Ready = 1'b0;
      EX_to_MEM_Valid = 1'b1;
      EX_to_MEM_Bus = mk_bus(1'b0, 1'b1, 3'd1, 32'h0000_ABCD, 1'b1, 5'd9, 32'h2002, 32'h80);
      tick();
      EX_to_MEM_Valid = 1'b0;
      checks++;
      if (Write_strb !== 4'b1100 || Write_data !== 32'hABCD_ABCD || MemWrite !== 1'b1 ||
          MemRead !== 1'b0 || Address !== 32'h2000) begin
         errors++;
         $display("FAIL sh_request: got strb=%b data=%h wr=%b rd=%b addr=%h expected strb=1100 data=abcdabcd wr=1 rd=0 addr=00002000",
                  Write_strb, Write_data, MemWrite, MemRead, Address);
      end
      Mem_Req_Ready = 1'b1;
      tick();
      Mem_Req_Ready = 1'b0;
      checks++;
      if (MEM_to_WB_Valid !== 1'b1 || MEM_to_WB_Bus[69] !== 1'b0 || MEM_to_WB_Bus[63:32] !== 32'h2002 ||
          {MemRead, MemWrite} !== 2'b00) begin
         errors++;
         $display("FAIL sh_done: got v=%b wen=%b res=%h req=%b expected v=1 wen=0 res=00002002 req=00",
                  MEM_to_WB_Valid, MEM_to_WB_Bus[69], MEM_to_WB_Bus[63:32], {MemRead, MemWrite});
      end
      tick();
   endtask

   task automatic test_wb_backpressure();
      logic [69:0] exp;
      WB_Allow_in = 1'b0;
      EX_to_MEM_Valid = 1'b1;
      EX_to_MEM_Bus = mk_bus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 5'd7, 32'h55, 32'h100);
      tick();
      EX_to_MEM_Bus = mk_bus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 5'd7, 32'h66, 32'h104);
      exp = {1'b1, 5'd7, 32'h55, 32'h100};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (MEM_to_WB_Valid !== 1'b1 || MEM_to_WB_Bus !== exp || MEM_Allow_in !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got v=%b bus=%h allow=%b expected v=1 bus=%h allow=0",
                     MEM_to_WB_Valid, MEM_to_WB_Bus, MEM_Allow_in, exp);
         end
         tick();
      end
      WB_Allow_in = 1'b1;
      #1;
      checks++;
      if (MEM_Allow_in !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_allow: got %b expected 1", MEM_Allow_in);
      end
      tick();
      EX_to_MEM_Valid = 1'b0;
      exp = {1'b1, 5'd7, 32'h66, 32'h104};
      checks++;
      if (MEM_to_WB_Valid !== 1'b1 || MEM_to_WB_Bus !== exp) begin
         errors++;
         $display("FAIL bp_capture: got v=%b bus=%h expected v=1 bus=%h", MEM_to_WB_Valid, MEM_to_WB_Bus, exp);
      end
      tick();
   endtask

   task automatic test_reset_mid_load();
      WB_Allow_in = 1'b1;
      Mem_Req_Ready = 1'b1;
      EX_to_MEM_Valid = 1'b1;
      EX_to_MEM_Bus = mk_bus(1'b1, 1'b0, 3'd2, 32'h0, 1'b1, 5'd4, 32'h3000, 32'h300);
      tick();
      EX_to_MEM_Valid = 1'b0;
      tick();
      Mem_Req_Ready = 1'b0;
      checks++;
      if (Read_data_Ready !== 1'b1) begin
         errors++;
         $display("FAIL rml_wait: got rdy=%b expected 1", Read_data_Ready);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      Read_data_Valid = 1'b1;
      Read_data = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({MEM_to_WB_Valid, Read_data_Ready, rdw_MEM_Bus[38], MEM_load_busy} !== 4'b0 || MEM_Allow_in !== 1'b1) begin
            errors++;
            $display("FAIL rml_idle: got v/rdy/mv/busy=%b allow=%b expected 0000 allow=1",
                     {MEM_to_WB_Valid, Read_data_Ready, rdw_MEM_Bus[38], MEM_load_busy}, MEM_Allow_in);
         end
         tick();
      end
      Read_data_Valid = 1'b0;
   endtask

   task automatic test_random();
      logic        occ, req_done, data_done, done_ph, exp_allow, cap, out_hs, in_req, in_wait;
      logic        ld, st;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] alu, sd, fr, r, cur_data;
      logic [106:0] cur;
      int          retired, issued, cyc, kind, k;
      occ = 1'b0; req_done = 1'b0; data_done = 1'b0;
      cur = '0; cur_data = '0;
      retired = 0; issued = 0; cyc = 0;
      EX_to_MEM_Valid = 1'b0;
      while (retired < 150 && cyc < 20000) begin
         if (!EX_to_MEM_Valid && issued < 150 && $urandom_range(0, 3) != 0) begin
            kind = $urandom_range(0, 2);
            if (kind == 1) begin
               k = $urandom_range(0, 4);
               f3 = (k == 3) ? 3'd4 : (k == 4) ? 3'd5 : 3'(k);
            end else if (kind == 2) begin
               f3 = 3'($urandom_range(0, 2));
            end else begin
               f3 = 3'($urandom_range(0, 7));
            end
            if (kind == 0 || f3[1:0] == 2'b00) off = 2'($urandom_range(0, 3));
            else if (f3[1:0] == 2'b01)         off = 2'($urandom_range(0, 1) * 2);
            else                               off = 2'd0;
            r = $urandom;
            alu = {r[31:2], off};
            EX_to_MEM_Bus = mk_bus(kind == 1, kind == 2, f3, $urandom, 1'($urandom_range(0, 1)),
                                   5'($urandom_range(0, 31)), alu, $urandom);
            EX_to_MEM_Valid = 1'b1;
            issued++;
         end
         WB_Allow_in = ($urandom_range(0, 3) != 0);
         Mem_Req_Ready = ($urandom_range(0, 2) == 0);
         Read_data_Valid = ($urandom_range(0, 1) == 1);
         Read_data = $urandom;
         #1;
         ld = cur[106]; st = cur[105]; f3 = cur[104:102]; sd = cur[101:70];
         alu = cur[63:32]; off = cur[33:32];
         in_req  = occ && (ld || st) && !req_done;
         in_wait = occ && ld && req_done && !data_done;
         done_ph = occ && !in_req && !in_wait;
         checks++;
         if (MemRead !== (in_req && ld) || MemWrite !== (in_req && st)) begin
            errors++;
            $display("FAIL rnd_req: got rd=%b wr=%b expected rd=%b wr=%b", MemRead, MemWrite, in_req && ld, in_req && st);
         end
         if (in_req) begin
            checks++;
            if (Address !== {alu[31:2], 2'b00}) begin
               errors++;
               $display("FAIL rnd_addr: got %h expected %h", Address, {alu[31:2], 2'b00});
            end
         end
         if (in_req && st) begin
            checks++;
            if (Write_strb !== ref_strb(f3, off) || Write_data !== ref_wdata(f3, sd)) begin
               errors++;
               $display("FAIL rnd_store: got strb=%b data=%h expected strb=%b data=%h",
                        Write_strb, Write_data, ref_strb(f3, off), ref_wdata(f3, sd));
            end
         end
         checks++;
         if (Read_data_Ready !== in_wait || MEM_load_busy !== (in_req && ld || in_wait) ||
             MEM_to_WB_Valid !== done_ph || rdw_MEM_Bus[38] !== occ) begin
            errors++;
            $display("FAIL rnd_status: got rdy/busy/v/mv=%b expected %b",
                     {Read_data_Ready, MEM_load_busy, MEM_to_WB_Valid, rdw_MEM_Bus[38]},
                     {in_wait, in_req && ld || in_wait, done_ph, occ});
         end
         if (done_ph) begin
            fr = ld ? ref_load(f3, off, cur_data) : alu;
            checks++;
            if (MEM_to_WB_Bus !== {cur[69] & ~st, cur[68:64], fr, cur[31:0]}) begin
               errors++;
               $display("FAIL rnd_wb_bus: got %h expected %h", MEM_to_WB_Bus, {cur[69] & ~st, cur[68:64], fr, cur[31:0]});
            end
            if (!st) begin
               checks++;
               if (rdw_MEM_Bus[37:0] !== {cur[69], cur[68:64], fr}) begin
                  errors++;
                  $display("FAIL rnd_fwd: got %h expected %h", rdw_MEM_Bus[37:0], {cur[69], cur[68:64], fr});
               end
            end
         end
         exp_allow = !occ || (done_ph && WB_Allow_in);
         checks++;
         if (MEM_Allow_in !== exp_allow) begin
            errors++;
            $display("FAIL rnd_allow: got %b expected %b", MEM_Allow_in, exp_allow);
         end
         out_hs = done_ph && WB_Allow_in;
         if (in_req && Mem_Req_Ready) req_done = 1'b1;
         if (in_wait && Read_data_Valid) begin
            data_done = 1'b1;
            cur_data = Read_data;
         end
         if (out_hs) begin
            occ = 1'b0;
            retired++;
         end
         cap = EX_to_MEM_Valid && exp_allow;
         if (cap) begin
            cur = EX_to_MEM_Bus;
            occ = 1'b1;
            req_done = 1'b0;
            data_done = 1'b0;
         end
         tick();
         if (cap) EX_to_MEM_Valid = 1'b0;
         cyc++;
      end
      checks++;
      if (retired != 150) begin
         errors++;
         $display("FAIL rnd_timeout: retired %0d expected 150", retired);
      end
      EX_to_MEM_Valid = 1'b0;
      Mem_Req_Ready = 1'b0;
      Read_data_Valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      EX_to_MEM_Valid = 1'b0;
      EX_to_MEM_Bus = '0;
      Mem_Req_Ready = 1'b0;
      Read_data = '0;
      Read_data_Valid = 1'b0;
      WB_Allow_in = 1'b0;
      test_reset();
      test_alu_passthrough();
      test_lb(1'b0, 32'hFFFF_FF80);
      test_lb(1'b1, 32'h0000_0080);
      test_sh_upper();
      test_wb_backpressure();
      test_reset_mid_load();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
